// File: rtl/grant_route_demux_2.sv
// Receive-side grant router: one merged TileLink grant stream is steered to one of two
// client ports through a one-entry output register; multi-beat grants stay locked to one port.
module grant_route_demux_2 #(
  parameter int DATA_BEATS = 8,
  parameter int ROUTE_BIT  = 1
) (
  input  logic        clk,
  input  logic        reset,
  output logic        in_ready,
  input  logic        in_valid,
  input  logic [2:0]  in_bits_addr_beat,
  input  logic [1:0]  in_bits_client_xact_id,
  input  logic        in_bits_manager_xact_id,
  input  logic        in_bits_is_builtin_type,
  input  logic [3:0]  in_bits_g_type,
  input  logic [63:0] in_bits_data,
  input  logic        out_0_ready,
  output logic        out_0_valid,
  output logic [2:0]  out_0_bits_addr_beat,
  output logic [1:0]  out_0_bits_client_xact_id,
  output logic        out_0_bits_manager_xact_id,
  output logic        out_0_bits_is_builtin_type,
  output logic [3:0]  out_0_bits_g_type,
  output logic [63:0] out_0_bits_data,
  input  logic        out_1_ready,
  output logic        out_1_valid,
  output logic [2:0]  out_1_bits_addr_beat,
  output logic [1:0]  out_1_bits_client_xact_id,
  output logic        out_1_bits_manager_xact_id,
  output logic        out_1_bits_is_builtin_type,
  output logic [3:0]  out_1_bits_g_type,
  output logic [63:0] out_1_bits_data,
  output logic        locked,
  output logic        beat_err
);
  // Handshake: a beat moves on any edge where valid & ready are both high; in_ready is
  // combinational so a full stage can accept a new beat in the cycle it drains.
  localparam int CW = $clog2(DATA_BEATS);
  localparam logic [CW-1:0] LAST_BEAT = CW'(DATA_BEATS - 1);

  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} lock_state_t;

  lock_state_t   state, state_next;
  logic [CW-1:0] cnt, cnt_next;
  logic          lock_dest, lock_dest_next;
  logic          full, dest, err;

  logic [2:0]  p_addr_beat;
  logic [1:0]  p_client_xact_id;
  logic        p_manager_xact_id;
  logic        p_is_builtin_type;
  logic [3:0]  p_g_type;
  logic [63:0] p_data;

  logic in_fire, out_fire, multi_beat, route;

  assign route      = in_bits_client_xact_id[ROUTE_BIT];
  assign multi_beat = (in_bits_is_builtin_type & (in_bits_g_type == 4'h5)) |
                      (!in_bits_is_builtin_type & (in_bits_g_type == 4'h0));
  assign out_fire   = full & (dest ? out_1_ready : out_0_ready);
  assign in_ready   = !full | out_fire;
  assign in_fire    = in_valid & in_ready;

  assign out_0_valid = full & !dest;
  assign out_1_valid = full & dest;
  assign locked      = (state == LOCKED);
  assign beat_err    = err;

  assign out_0_bits_addr_beat       = p_addr_beat;
  assign out_0_bits_client_xact_id  = p_client_xact_id;
  assign out_0_bits_manager_xact_id = p_manager_xact_id;
  assign out_0_bits_is_builtin_type = p_is_builtin_type;
  assign out_0_bits_g_type          = p_g_type;
  assign out_0_bits_data            = p_data;
  assign out_1_bits_addr_beat       = p_addr_beat;
  assign out_1_bits_client_xact_id  = p_client_xact_id;
  assign out_1_bits_manager_xact_id = p_manager_xact_id;
  assign out_1_bits_is_builtin_type = p_is_builtin_type;
  assign out_1_bits_g_type          = p_g_type;
  assign out_1_bits_data            = p_data;

  // Lock FSM only moves on accepted multi-beat beats; single-beat grants leave it alone.
  always_comb begin
    state_next     = state;
    cnt_next       = cnt;
    lock_dest_next = lock_dest;
    if (in_fire && multi_beat) begin
      case (state)
        IDLE: begin
          state_next     = LOCKED;
          lock_dest_next = route;
          cnt_next       = CW'(1);
        end
        LOCKED: begin
          if (cnt == LAST_BEAT) begin
            state_next = IDLE;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt + 1'b1;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      full  <= 1'b0;
      err   <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (in_fire) full <= 1'b1;
      else if (out_fire) full <= 1'b0;
      if (in_fire && multi_beat && (32'(in_bits_addr_beat) != 32'(cnt))) err <= 1'b1;
    end
  end

  // Payload, destination and lock target are qualified by full/lock, so they need no reset.
  always_ff @(posedge clk) begin
    lock_dest <= lock_dest_next;
    if (in_fire) begin
      dest              <= (state == LOCKED) ? lock_dest : route;
      p_addr_beat       <= in_bits_addr_beat;
      p_client_xact_id  <= in_bits_client_xact_id;
      p_manager_xact_id <= in_bits_manager_xact_id;
      p_is_builtin_type <= in_bits_is_builtin_type;
      p_g_type          <= in_bits_g_type;
      p_data            <= in_bits_data;
    end
  end
endmodule

// File: tb/tb_grant_route_demux_2.sv
// Directed bench for grant_route_demux_2: expected beats are queued at issue time and a
// monitor pops and compares them whenever a port completes a handshake.
module tb_grant_route_demux_2;
  localparam int W = 76;  // {port, addr_beat, client_xact_id, manager_xact_id, builtin, g_type, data}

  logic        clk = 1'b0;
  logic        reset;
  logic        in_ready, in_valid;
  logic [2:0]  in_bits_addr_beat;
  logic [1:0]  in_bits_client_xact_id;
  logic        in_bits_manager_xact_id, in_bits_is_builtin_type;
  logic [3:0]  in_bits_g_type;
  logic [63:0] in_bits_data;
  logic        out_0_ready, out_0_valid, out_1_ready, out_1_valid;
  logic [2:0]  out_0_bits_addr_beat, out_1_bits_addr_beat;
  logic [1:0]  out_0_bits_client_xact_id, out_1_bits_client_xact_id;
  logic        out_0_bits_manager_xact_id, out_1_bits_manager_xact_id;
  logic        out_0_bits_is_builtin_type, out_1_bits_is_builtin_type;
  logic [3:0]  out_0_bits_g_type, out_1_bits_g_type;
  logic [63:0] out_0_bits_data, out_1_bits_data;
  logic        locked, beat_err;

  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int last_wait = 0;

  grant_route_demux_2 #(.DATA_BEATS(8), .ROUTE_BIT(1)) dut (
    .clk(clk), .reset(reset),
    .in_ready(in_ready), .in_valid(in_valid),
    .in_bits_addr_beat(in_bits_addr_beat),
    .in_bits_client_xact_id(in_bits_client_xact_id),
    .in_bits_manager_xact_id(in_bits_manager_xact_id),
    .in_bits_is_builtin_type(in_bits_is_builtin_type),
    .in_bits_g_type(in_bits_g_type),
    .in_bits_data(in_bits_data),
    .out_0_ready(out_0_ready), .out_0_valid(out_0_valid),
    .out_0_bits_addr_beat(out_0_bits_addr_beat),
    .out_0_bits_client_xact_id(out_0_bits_client_xact_id),
    .out_0_bits_manager_xact_id(out_0_bits_manager_xact_id),
    .out_0_bits_is_builtin_type(out_0_bits_is_builtin_type),
    .out_0_bits_g_type(out_0_bits_g_type),
    .out_0_bits_data(out_0_bits_data),
    .out_1_ready(out_1_ready), .out_1_valid(out_1_valid),
    .out_1_bits_addr_beat(out_1_bits_addr_beat),
    .out_1_bits_client_xact_id(out_1_bits_client_xact_id),
    .out_1_bits_manager_xact_id(out_1_bits_manager_xact_id),
    .out_1_bits_is_builtin_type(out_1_bits_is_builtin_type),
    .out_1_bits_g_type(out_1_bits_g_type),
    .out_1_bits_data(out_1_bits_data),
    .locked(locked), .beat_err(beat_err)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic do_reset();
    reset    = 1'b1;
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Driver: called at a negedge; holds the beat until accepted and returns at the next
  // negedge with in_valid still high so back-to-back calls stream one beat per cycle.
  task automatic send_beat(input logic [2:0] ab, input logic [1:0] id, input logic mx,
                           input logic bi, input logic [3:0] gt, input logic [63:0] d,
                           input logic port);
    in_valid                = 1'b1;
    in_bits_addr_beat       = ab;
    in_bits_client_xact_id  = id;
    in_bits_manager_xact_id = mx;
    in_bits_is_builtin_type = bi;
    in_bits_g_type          = gt;
    in_bits_data            = d;
    last_wait = 0;
    #4;
    while (!in_ready && last_wait < 50) begin
      @(negedge clk);
      #4;
      last_wait++;
    end
    if (!in_ready) begin
      errors++;
      checks++;
      $display("FAIL accept_timeout: beat data %0h never accepted", d);
    end else begin
      exp_q.push_back({port, ab, id, mx, bi, gt, d});
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // 8-beat burst with addr_beat 0..7; beat 0 carries first_id, the rest later_id.
  task automatic burst(input logic bi, input logic [3:0] gt, input logic [1:0] first_id,
                       input logic [1:0] later_id, input logic port, input logic [63:0] base,
                       input string tag);
    for (int i = 0; i < 8; i++) begin
      send_beat(3'(i), (i == 0) ? first_id : later_id, i[0], bi, gt, base + 64'(i), port);
      if (i == 0) check({tag, "_locked_after_first"}, 64'(locked), 64'd1);
      if (i > 0) check({tag, "_no_stall"}, 64'(last_wait), 64'd0);
    end
    check({tag, "_unlocked_after_last"}, 64'(locked), 64'd0);
  endtask

  // Scoreboard monitor: samples 1 time unit before each rising edge.
  always begin
    @(negedge clk);
    #4;
    if (!reset) begin
      for (int k = 0; k < 2; k++) begin
        logic v, r;
        logic [W-1:0] act, exp;
        v = (k == 0) ? out_0_valid : out_1_valid;
        r = (k == 0) ? out_0_ready : out_1_ready;
        act = (k == 0)
          ? {1'b0, out_0_bits_addr_beat, out_0_bits_client_xact_id, out_0_bits_manager_xact_id,
             out_0_bits_is_builtin_type, out_0_bits_g_type, out_0_bits_data}
          : {1'b1, out_1_bits_addr_beat, out_1_bits_client_xact_id, out_1_bits_manager_xact_id,
             out_1_bits_is_builtin_type, out_1_bits_g_type, out_1_bits_data};
        if (v && r) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL port%0d_unexpected: got %0h expected nothing", k, act);
          end else begin
            exp = exp_q.pop_front();
            if (act !== exp) begin
              errors++;
              $display("FAIL port%0d_beat: got %0h expected %0h", k, act, exp);
            end
          end
        end
      end
    end
  end

  initial begin
    in_valid = 0; in_bits_addr_beat = 0; in_bits_client_xact_id = 0;
    in_bits_manager_xact_id = 0; in_bits_is_builtin_type = 0; in_bits_g_type = 0;
    in_bits_data = 0; out_0_ready = 1; out_1_ready = 1; reset = 1;
    @(negedge clk);
    do_reset();
    check("reset_out0_valid", 64'(out_0_valid), 64'd0);
    check("reset_out1_valid", 64'(out_1_valid), 64'd0);
    check("reset_locked", 64'(locked), 64'd0);
    check("reset_beat_err", 64'(beat_err), 64'd0);
    check("reset_in_ready", 64'(in_ready), 64'd1);

    // Single-beat builtin grant, id 2'b10 -> port 1
    send_beat(3'd0, 2'b10, 1'b1, 1'b1, 4'h3, 64'h1111_2222_3333_4444, 1'b1);
    check("single_out1_valid", 64'(out_1_valid), 64'd1);
    check("single_out0_valid", 64'(out_0_valid), 64'd0);
    check("single_locked", 64'(locked), 64'd0);
    check("single_data", out_1_bits_data, 64'h1111_2222_3333_4444);
    idle(2);

    // Builtin g_type 5 burst: later beats carry id 2'b10 but stay on port 0
    burst(1'b1, 4'h5, 2'b00, 2'b10, 1'b0, 64'hB000_0000_0000_0000, "burst0");
    idle(2);
    check("burst0_beat_err", 64'(beat_err), 64'd0);

    // Backpressure on port 0; port 1 ready must not matter
    out_0_ready = 1'b0;
    send_beat(3'd0, 2'b01, 1'b0, 1'b1, 4'h3, 64'hCAFE_0000_0000_0001, 1'b0);
    in_bits_data = 64'hDEAD_DEAD_DEAD_DEAD;
    for (int i = 0; i < 3; i++) begin
      #4;
      check("stall_in_ready", 64'(in_ready), 64'd0);
      check("stall_payload", out_0_bits_data, 64'hCAFE_0000_0000_0001);
      @(negedge clk);
    end
    out_0_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      send_beat(3'(i), 2'b00, 1'b0, i[0], (i[0]) ? 4'h2 : 4'h1, 64'hC000_0000_0000_0100 + 64'(i), 1'b0);
      check("stream_no_stall", 64'(last_wait), 64'd0);
    end
    idle(2);

    // Burst to port 1 with addr_beat 0,1,3,4,5,6,7,0 -> error after beat 2
    for (int i = 0; i < 8; i++) begin
      send_beat((i < 2) ? 3'(i) : 3'(i + 1), (i == 0) ? 2'b10 : 2'b00, 1'b0, 1'b1, 4'h5,
                64'hE000_0000_0000_0000 + 64'(i), 1'b1);
      if (i == 1) check("err_clear_before_bad", 64'(beat_err), 64'd0);
      if (i == 2) check("err_set_after_bad", 64'(beat_err), 64'd1);
    end
    check("err_burst_unlocked", 64'(locked), 64'd0);
    idle(3);
    check("err_sticky", 64'(beat_err), 64'd1);

    // Reset mid-burst: beat 3 is held (port stalled) and must be dropped
    for (int i = 0; i < 4; i++)
      send_beat(3'(i), 2'b00, 1'b0, 1'b1, 4'h5, 64'hF000_0000_0000_0000 + 64'(i), 1'b0);
    out_0_ready = 1'b0;
    in_valid    = 1'b0;
    check("midburst_pending", 64'(exp_q.size()), 64'd1);
    check("midburst_locked", 64'(locked), 64'd1);
    do_reset();
    exp_q.delete();
    out_0_ready = 1'b1;
    check("post_reset_out0_valid", 64'(out_0_valid), 64'd0);
    check("post_reset_locked", 64'(locked), 64'd0);
    check("post_reset_beat_err", 64'(beat_err), 64'd0);
    burst(1'b0, 4'h0, 2'b10, 2'b00, 1'b1, 64'h5000_0000_0000_0000, "nonbuiltin1");
    idle(2);
    check("nonbuiltin1_beat_err", 64'(beat_err), 64'd0);

    // Back-to-back bursts: port 0 then port 1 with no idle cycle
    burst(1'b1, 4'h5, 2'b00, 2'b10, 1'b0, 64'h6000_0000_0000_0000, "b2b_p0");
    send_beat(3'd0, 2'b10, 1'b0, 1'b1, 4'h5, 64'h7000_0000_0000_0000, 1'b1);
    check("b2b_retarget_no_stall", 64'(last_wait), 64'd0);
    check("b2b_relocked", 64'(locked), 64'd1);
    for (int i = 1; i < 8; i++)
      send_beat(3'(i), 2'b00, 1'b1, 1'b1, 4'h5, 64'h7000_0000_0000_0000 + 64'(i), 1'b1);
    check("b2b_p1_unlocked", 64'(locked), 64'd0);
    idle(4);
    check("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
